// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one endpoint-pair command, walks the line
// one point per clock and writes clipped pixels into a downstream FIFO.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   SETUP | derive deltas, step directions and initial error from the latched command
//   DRAW  | one Bresenham step per non-stalled cycle; after the end point, one drain cycle
//   DONE  | done pulse, then back to IDLE

module line_rasterizer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [31:0] colour,
    output logic [63:0] pixel_data,
    output logic        pixel_data_valid,
    input  logic        pixel_fifo_full,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [16:0] X_LIM = 17'(SCREEN_WIDTH);
    localparam logic [16:0] Y_LIM = 17'(SCREEN_HEIGHT);

    state_t             state_q, state_d;
    logic [15:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [31:0]        colour_q, colour_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    logic signed [17:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic               last_q, last_d;
    logic [63:0]        pixel_q, pixel_d;
    logic               valid_q, valid_d;

    logic [15:0]        adx, ady;
    logic signed [17:0] e2;
    logic signed [17:0] err_step;
    logic               step_x, step_y;
    logic               in_bounds, at_end;
    logic [15:0]        x_inc, y_inc;

    assign adx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign ady = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);

    // Both step decisions use the pre-step error; a diagonal step applies both.
    assign e2       = err_q <<< 1;
    assign step_x   = (e2 >= dy_q);
    assign step_y   = (e2 <= dx_q);
    assign err_step = err_q + (step_x ? dy_q : 18'sd0) + (step_y ? dx_q : 18'sd0);

    assign x_inc     = sx_neg_q ? 16'hFFFF : 16'h0001;
    assign y_inc     = sy_neg_q ? 16'hFFFF : 16'h0001;
    assign in_bounds = ({1'b0, x_q} < X_LIM) && ({1'b0, y_q} < Y_LIM);
    assign at_end    = (x_q == x1_q) && (y_q == y1_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            colour_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            last_q   <= 1'b0;
            pixel_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            colour_q <= colour_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            last_q   <= last_d;
            pixel_q  <= pixel_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        last_d   = last_q;
        pixel_d  = pixel_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    x1_d     = x1;
                    y1_d     = y1;
                    colour_d = colour;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                dx_d     = $signed({2'b00, adx});
                dy_d     = -$signed({2'b00, ady});
                err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                x_d      = x0_q;
                y_d      = y0_q;
                last_d   = 1'b0;
                state_d  = DRAW;
            end

            DRAW: begin
                // The end point's pixel is visible for one more DRAW cycle so
                // that valid never overlaps the done pulse.
                if (last_q) begin
                    state_d = DONE;
                end else if (!pixel_fifo_full) begin
                    if (in_bounds) begin
                        pixel_d = {x_q, y_q, colour_q};
                        valid_d = 1'b1;
                    end
                    if (at_end) begin
                        last_d = 1'b1;
                    end else begin
                        err_d = err_step;
                        if (step_x) x_d = x_q + x_inc;
                        if (step_y) y_d = y_q + y_inc;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign pixel_data       = pixel_q;
    assign pixel_data_valid = valid_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: hand-computed pixel lists, cycle positions
// and done timing for straight, steep, reversed, stalled, clipped and reset cases.

module tb_line_rasterizer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [31:0] colour = '0;
    logic [63:0] pixel_data;
    logic        pixel_data_valid;
    logic        pixel_fifo_full = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [63:0] got_q[$];
    int          got_k[$];
    int          done_k;
    logic [63:0] ep[$];
    int          ek[$];
    int          stall_s = -1;
    int          stall_len = 0;
    int          cnt;

    line_rasterizer #(.SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .x0              (x0),
        .y0              (y0),
        .x1              (x1),
        .y1              (y1),
        .colour          (colour),
        .pixel_data      (pixel_data),
        .pixel_data_valid(pixel_data_valid),
        .pixel_fifo_full (pixel_fifo_full),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] pix(input logic [15:0] x, input logic [15:0] y,
                                        input logic [31:0] c);
        return {x, y, c};
    endfunction

    // Drives one command for a single edge; the caller guarantees IDLE.
    task automatic send(input logic [15:0] ax0, input logic [15:0] ay0,
                        input logic [15:0] ax1, input logic [15:0] ay1,
                        input logic [31:0] c);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; colour = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Sample k is taken 1 time unit after edge T+k, T being the accept edge.
    task automatic collect(input string tag, input int budget);
        got_q.delete();
        got_k.delete();
        done_k = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (pixel_data_valid) begin
                got_q.push_back(pixel_data);
                got_k.push_back(k);
            end else if (got_q.size() > 0) begin
                check({tag, " hold"}, pixel_data, got_q[got_q.size()-1]);
            end
            pixel_fifo_full = (k >= stall_s) && (k < stall_s + stall_len);
            if (done) begin
                done_k = k;
                check({tag, " valid_at_done"}, pixel_data_valid, 1'b0);
                break;
            end
        end
        pixel_fifo_full = 1'b0;
        check({tag, " done_seen"}, (done_k != -1), 1'b1);
        if (done_k != -1) begin
            step();
            check({tag, " done_width"}, done, 1'b0);
            check({tag, " idle_ready"}, cmd_ready, 1'b1);
        end
    endtask

    task automatic check_line(input string tag, input int exp_done);
        check({tag, " count"}, got_q.size(), ep.size());
        for (int i = 0; i < ep.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s pix%0d", tag, i), got_q[i], ep[i]);
                check($sformatf("%s cyc%0d", tag, i), got_k[i], ek[i]);
            end
        end
        check({tag, " done_cycle"}, done_k, exp_done);
    endtask

    initial begin
        reset_n = 1'b0;
        step();
        step();
        check("rst valid", pixel_data_valid, 1'b0);
        check("rst done", done, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ready", cmd_ready, 1'b1);
        check("rst data", pixel_data, 64'h0);
        reset_n = 1'b1;
        step();

        // Horizontal line, first pixel two edges after acceptance.
        send(16'd0, 16'd0, 16'd3, 16'd0, 32'h00FF0000);
        check("horiz busy", busy, 1'b1);
        check("horiz ready", cmd_ready, 1'b0);
        ep = '{64'h0000_0000_00FF0000, 64'h0001_0000_00FF0000,
               64'h0002_0000_00FF0000, 64'h0003_0000_00FF0000};
        ek = '{2, 3, 4, 5};
        collect("horiz", 50);
        check_line("horiz", 6);

        send(16'd0, 16'd0, 16'd1, 16'd3, 32'h11223344);
        ep = '{pix(0, 0, 32'h11223344), pix(0, 1, 32'h11223344),
               pix(1, 2, 32'h11223344), pix(1, 3, 32'h11223344)};
        ek = '{2, 3, 4, 5};
        collect("steep", 50);
        check_line("steep", 6);

        send(16'd5, 16'd5, 16'd2, 16'd2, 32'hA5A5A5A5);
        ep = '{pix(5, 5, 32'hA5A5A5A5), pix(4, 4, 32'hA5A5A5A5),
               pix(3, 3, 32'hA5A5A5A5), pix(2, 2, 32'hA5A5A5A5)};
        ek = '{2, 3, 4, 5};
        collect("revdiag", 50);
        check_line("revdiag", 6);

        // Shallow slope exercising simultaneous x/y steps.
        send(16'd0, 16'd0, 16'd4, 16'd2, 32'h0000BEEF);
        ep = '{pix(0, 0, 32'h0000BEEF), pix(1, 1, 32'h0000BEEF), pix(2, 1, 32'h0000BEEF),
               pix(3, 2, 32'h0000BEEF), pix(4, 2, 32'h0000BEEF)};
        ek = '{2, 3, 4, 5, 6};
        collect("slope", 50);
        check_line("slope", 7);

        // Stall for 5 edges right after the third pixel is seen.
        stall_s = 4;
        stall_len = 5;
        send(16'd0, 16'd0, 16'd7, 16'd0, 32'h00000077);
        ep.delete();
        for (int i = 0; i < 8; i++) ep.push_back(pix(16'(i), 0, 32'h00000077));
        ek = '{2, 3, 4, 10, 11, 12, 13, 14};
        collect("stall", 60);
        check_line("stall", 15);
        stall_s = -1;
        stall_len = 0;

        send(16'd638, 16'd0, 16'd641, 16'd0, 32'h00C0FFEE);
        ep = '{pix(638, 0, 32'h00C0FFEE), pix(639, 0, 32'h00C0FFEE)};
        ek = '{2, 3};
        collect("clipx", 50);
        check_line("clipx", 6);

        send(16'd5, 16'd478, 16'd5, 16'd481, 32'h00000042);
        ep = '{pix(5, 478, 32'h00000042), pix(5, 479, 32'h00000042)};
        ek = '{2, 3};
        collect("clipy", 50);
        check_line("clipy", 6);

        send(16'd700, 16'd500, 16'd702, 16'd500, 32'h12345678);
        ep.delete();
        ek.delete();
        collect("allclip", 50);
        check_line("allclip", 5);

        send(16'd10, 16'd20, 16'd10, 16'd20, 32'hDEADBEEF);
        ep = '{64'h000A_0014_DEADBEEF};
        ek = '{2};
        collect("single", 50);
        check_line("single", 3);

        // Reset after ten pixels abandons the line.
        send(16'd0, 16'd0, 16'd100, 16'd0, 32'h0000FFFF);
        cnt = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (pixel_data_valid) cnt++;
        end
        check("midrst count", cnt, 10);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst valid", pixel_data_valid, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst ready", cmd_ready, 1'b1);
        check("midrst data", pixel_data, 64'h0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (pixel_data_valid || done) cnt++;
        end
        check("midrst quiet", cnt, 0);
        send(16'd2, 16'd3, 16'd4, 16'd3, 32'h0BADF00D);
        ep = '{pix(2, 3, 32'h0BADF00D), pix(3, 3, 32'h0BADF00D), pix(4, 3, 32'h0BADF00D)};
        ek = '{2, 3, 4};
        collect("postrst", 50);
        check_line("postrst", 5);

        // cmd_valid held through a line: inputs change mid-line and are ignored,
        // then the new command is taken on the first IDLE cycle.
        x0 = 16'd0; y0 = 16'd0; x1 = 16'd1; y1 = 16'd0; colour = 32'h000000C1;
        cmd_valid = 1'b1;
        step();
        x1 = 16'd5;
        colour = 32'h000000C2;
        ep = '{pix(0, 0, 32'h000000C1), pix(1, 0, 32'h000000C1)};
        ek = '{2, 3};
        collect("heldA", 50);
        check_line("heldA", 4);
        check("heldA idle_busy", busy, 1'b0);
        step();
        check("heldB accepted", busy, 1'b1);
        check("heldB ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        ep.delete();
        for (int i = 0; i < 6; i++) ep.push_back(pix(16'(i), 0, 32'h000000C2));
        ek = '{2, 3, 4, 5, 6, 7};
        collect("heldB", 50);
        check_line("heldB", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
